flop_chain_checker: RTL and testbench

FLOP_CHAIN_CHECKER -- requirements
Module: flop_chain_checker

---
 rtl/flop_chk_pkg.sv | 17 +
 rtl/flop_chk_model.sv | 40 ++++
 rtl/flop_chain_checker.sv | 126 ++++++++++++
 tb/tb_flop_chain_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flop_chk_pkg.sv
// Shared definitions for flop-chain checkers: FSM state encoding and the legal
// range of chain depths, plus the fill-counter width that covers that range.
package flop_chk_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StCheck = 2'd2
  } chk_state_e;

  localparam int unsigned DepthMin = 1;
  localparam int unsigned DepthMax = 16;

  // Wide enough for the fill counter to reach DepthMax.
  localparam int unsigned FillW = $clog2(DepthMax + 1);

endpackage

// File: rtl/flop_chk_model.sv
// Behavioural shift model of a DEPTH-stage flop chain; o_last is the value the
// real chain should present at its output on the current cycle.
module flop_chk_model
  import flop_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_shift,
  input  logic i_clear,
  input  logic i_a,
  output logic o_last
);

  logic [DEPTH-1:0] r_stage;
  logic [DEPTH-1:0] w_next;

  always_comb begin
    w_next    = r_stage;
    w_next[0] = i_a;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_next[i] = r_stage[i-1];
    end
  end

  // Clear has priority: an invalidated history must never be compared against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (i_clear) begin
      r_stage <= '0;
    end else if (i_shift) begin
      r_stage <= w_next;
    end
  end

  assign o_last = r_stage[DEPTH-1];

endmodule

// File: rtl/flop_chain_checker.sv
// Self-checking monitor for a simulated flop chain: predicts z from a, compares
// 4-state exact once the model is full, and keeps saturating pass/fail statistics.
module flop_chain_checker
  import flop_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          a,
  input  logic          z,
  output logic          expected,
  output logic          mismatch,
  output logic          fail,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] first_err_cyc,
  output logic [1:0]    state
);

  localparam logic [FillW-1:0] FillDone = FillW'(DEPTH);
  localparam logic [CW-1:0]    CntMax   = '1;

  chk_state_e       r_state;
  logic [FillW-1:0] r_fill;
  logic [CW-1:0]    r_cyc;
  logic [CW-1:0]    r_match;
  logic [CW-1:0]    r_err;
  logic [CW-1:0]    r_first;
  logic             r_mismatch;
  logic             r_fail;

  logic             w_expected;
  logic             w_cmp;
  logic             w_pass;
  logic             w_bad;
  logic [FillW-1:0] w_fill_inc;

  flop_chk_model #(
    .DEPTH (DEPTH)
  ) u_model (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_shift (en),
    .i_clear (!en),
    .i_a     (a),
    .o_last  (w_expected)
  );

  // A compare happens on every edge seen in CHECK, including the one where en
  // drops, so a failure coinciding with the disable is still counted.
  assign w_cmp      = (r_state == StCheck);
  assign w_pass     = (z === w_expected);
  assign w_bad      = w_cmp && !w_pass;
  assign w_fill_inc = r_fill + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_fill  <= '0;
    end else if (!en) begin
      r_state <= StIdle;
      r_fill  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state <= StFill;
          r_fill  <= '0;
        end
        StFill: begin
          r_fill <= w_fill_inc;
          if (w_fill_inc == FillDone) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          r_state <= StCheck;
        end
        default: begin
          r_state <= StIdle;
          r_fill  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc      <= '0;
      r_match    <= '0;
      r_err      <= '0;
      r_first    <= '0;
      r_mismatch <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      if (r_cyc != CntMax) begin
        r_cyc <= r_cyc + 1'b1;
      end
      r_mismatch <= w_bad;
      if (w_cmp && w_pass && (r_match != CntMax)) begin
        r_match <= r_match + 1'b1;
      end
      if (w_bad) begin
        if (r_err != CntMax) begin
          r_err <= r_err + 1'b1;
        end
        // Only the first failure since reset is timestamped.
        if (!r_fail) begin
          r_fail  <= 1'b1;
          r_first <= r_cyc;
        end
      end
    end
  end

  assign expected      = w_expected;
  assign mismatch      = r_mismatch;
  assign fail          = r_fail;
  assign match_count   = r_match;
  assign err_count     = r_err;
  assign first_err_cyc = r_first;
  assign state         = r_state;

endmodule

// File: tb/tb_flop_chain_checker.sv
// Bench for flop_chain_checker: table vectors, corner-case sequences and random
// traffic, all checked against a queue-based reference of the checker's rules.
module tb_flop_chain_checker;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic a;
  logic z;

  logic        expected, mismatch, fail;
  logic [15:0] match_count, err_count, first_err_cyc;
  logic [1:0]  state;

  logic        s_expected, s_mismatch, s_fail;
  logic [3:0]  s_match_count, s_err_count, s_first_err_cyc;
  logic [1:0]  s_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of enabled samples and run length since invalidation.
  logic hist[$];
  int   run, cyc, mc, ec, fe;
  bit   fl, mm;
  // Ideal chain: a delayed by DEPTH clock edges regardless of en.
  logic ideal[DEPTH];

  typedef struct {
    logic       en, a, z;
    logic [1:0] st;
    logic       ex, mm, fl;
    int         mc, ec, fe;
  } vec_t;

  vec_t tbl[14];

  flop_chain_checker #(
    .DEPTH (DEPTH),
    .CW    (16)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .a             (a),
    .z             (z),
    .expected      (expected),
    .mismatch      (mismatch),
    .fail          (fail),
    .match_count   (match_count),
    .err_count     (err_count),
    .first_err_cyc (first_err_cyc),
    .state         (state)
  );

  flop_chain_checker #(
    .DEPTH (DEPTH),
    .CW    (4)
  ) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .a             (a),
    .z             (z),
    .expected      (s_expected),
    .mismatch      (s_mismatch),
    .fail          (s_fail),
    .match_count   (s_match_count),
    .err_count     (s_err_count),
    .first_err_cyc (s_first_err_cyc),
    .state         (s_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic logic ref_exp();
    return (hist.size() == DEPTH) ? hist[0] : 1'b0;
  endfunction

  function automatic int ref_state();
    if (run == 0) return 0;
    if (run <= int'(DEPTH)) return 1;
    return 2;
  endfunction

  task automatic ref_edge(input logic e, input logic av, input logic zv);
    logic exp_b;
    exp_b = ref_exp();
    mm    = 1'b0;
    if (run >= int'(DEPTH) + 1) begin
      if (zv !== exp_b) begin
        ec++;
        mm = 1'b1;
        if (!fl) begin
          fl = 1'b1;
          fe = cyc;
        end
      end else begin
        mc++;
      end
    end
    if (e) begin
      hist.push_back(av);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      run++;
    end else begin
      hist.delete();
      run = 0;
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [63:0] g, w;
    g = {11'd0, state, expected, mismatch, fail, match_count, err_count, first_err_cyc};
    w = {11'd0, 2'(ref_state()), ref_exp(), mm, fl,
         16'(sat(mc, 16)), 16'(sat(ec, 16)), 16'(sat(fe, 16))};
    chk("model_cw16", g, w);
    g = {47'd0, s_state, s_expected, s_mismatch, s_fail,
         s_match_count, s_err_count, s_first_err_cyc};
    w = {47'd0, 2'(ref_state()), ref_exp(), mm, fl,
         4'(sat(mc, 4)), 4'(sat(ec, 4)), 4'(sat(fe, 4))};
    chk("model_cw4", g, w);
  endtask

  task automatic step(input logic e, input logic av, input logic zv);
    en = e;
    a  = av;
    z  = zv;
    @(posedge clk);
    #1;
    ref_edge(e, av, zv);
    for (int i = DEPTH - 1; i > 0; i--) ideal[i] = ideal[i-1];
    ideal[0] = av;
    check_all();
  endtask

  // Called 1 time unit after a rising edge; reset is applied and released mid-cycle.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_imm_cw16", {11'd0, state, expected, mismatch, fail, match_count, err_count,
                         first_err_cyc}, 64'd0);
    chk("rst_imm_cw4", {47'd0, s_state, s_expected, s_mismatch, s_fail, s_match_count,
                        s_err_count, s_first_err_cyc}, 64'd0);
    hist.delete();
    run = 0; cyc = 0; mc = 0; ec = 0; fe = 0; fl = 1'b0; mm = 1'b0;
    for (int i = 0; i < DEPTH; i++) ideal[i] = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] g, w;
    logic        zv;
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 1'b0;
    z     = 1'b0;

    //            en    a     z     st    ex    mm    fl    mc ec fe
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 2, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 4, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 5, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 6, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 7, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 7, 1, 12};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8, 1, 12};

    @(posedge clk);
    #1;
    do_reset();

    // Ideal chain fill/check, then z forced low on an edge expecting 1.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].a, tbl[i].z);
      g = {11'd0, state, expected, mismatch, fail, match_count, err_count, first_err_cyc};
      w = {11'd0, tbl[i].st, tbl[i].ex, tbl[i].mm, tbl[i].fl,
           16'(tbl[i].mc), 16'(tbl[i].ec), 16'(tbl[i].fe)};
      chk($sformatf("table_row%0d", i), g, w);
    end

    // Unknown z on CHECK edges 3 and 7 while expected is 1.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, ideal[DEPTH-1]);
    chk("x_enter_check", 64'(state), 64'd2);
    for (int k = 1; k <= 8; k++) begin
      zv = (k == 3 || k == 7) ? 1'bx : ideal[DEPTH-1];
      step(1'b1, 1'b1, zv);
    end
    chk("x_err_count", 64'(err_count), 64'd2);
    chk("x_first_err", 64'(first_err_cyc), 64'd7);
    chk("x_match_count", 64'(match_count), 64'd6);
    chk("x_fail", 64'(fail), 64'd1);

    // Disable for two edges mid-CHECK, then refill.
    step(1'b0, 1'b1, ideal[DEPTH-1]);
    step(1'b0, 1'b1, ideal[DEPTH-1]);
    chk("dis_idle", 64'(state), 64'd0);
    chk("dis_match_kept", 64'(match_count), 64'd7);
    chk("dis_err_kept", 64'(err_count), 64'd2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, ideal[DEPTH-1]);
      chk($sformatf("refill_state%0d", i), 64'({state, match_count}), 64'({2'd1, 16'd7}));
    end
    step(1'b1, 1'b1, ideal[DEPTH-1]);
    chk("refill_done", 64'({state, match_count}), 64'({2'd2, 16'd7}));
    step(1'b1, 1'b1, ideal[DEPTH-1]);
    chk("resume_match", 64'(match_count), 64'd8);
    chk("resume_first_kept", 64'(first_err_cyc), 64'd7);

    // Reset mid-CHECK discards history.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, ideal[DEPTH-1]);
    chk("rst_refill", 64'({state, match_count}), 64'({2'd2, 16'd0}));
    step(1'b1, 1'b1, ideal[DEPTH-1]);
    chk("rst_first_cmp", 64'(match_count), 64'd1);

    // Twenty consecutive mismatches saturate the narrow counter.
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), ~ref_exp());
    chk("sat_err_cw4", 64'(s_err_count), 64'd15);
    chk("sat_fail_cw4", 64'(s_fail), 64'd1);
    chk("sat_err_cw16", 64'(err_count), 64'd20);

    // Random traffic with occasional disables, corruptions and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           ideal[DEPTH-1] ^ 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
